// File: rtl/mmrb_pkg.sv
// Shared types and address map for the matrix-multiplier register bank.
// Holds the control FSM encoding, fixed register addresses and status bit positions.
package mmrb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPTURE
    } state_t;

    localparam logic [8:0] RES_BASE   = 9'h100;
    localparam logic [8:0] START_ADDR = 9'h180;
    localparam logic [8:0] STAT_ADDR  = 9'h184;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/mmrb_addr_decode.sv
// Combinational byte-address decoder for the register bank.
// Classifies an access as operand/result/start/status or misaligned/unmapped.
module mmrb_addr_decode
    import mmrb_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int NUM_OPS = 64,
    parameter int NUM_RES = 16
) (
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic                       i_write,
    output logic [NUM_OPS-1:0]         o_op_we,
    output logic [$clog2(NUM_OPS)-1:0] o_op_idx,
    output logic [$clog2(NUM_RES)-1:0] o_res_idx,
    output logic                       o_is_op,
    output logic                       o_is_res,
    output logic                       o_is_start,
    output logic                       o_is_stat,
    output logic                       o_misaligned,
    output logic                       o_unmapped
);

    localparam int          OP_IW   = $clog2(NUM_OPS);
    localparam int          RES_IW  = $clog2(NUM_RES);
    localparam logic [31:0] OP_END  = 32'(NUM_OPS * 4);
    localparam logic [31:0] RES_LO  = 32'(RES_BASE);
    localparam logic [31:0] RES_END = RES_LO + 32'(NUM_RES * 4);

    logic [31:0] w_addr;
    assign w_addr = 32'(i_addr);

    // NOTE: every output gets a default at the top so no path can infer a latch.
    always_comb begin
        o_misaligned = |i_addr[1:0];
        o_is_op      = !o_misaligned && (w_addr < OP_END);
        o_is_res     = !o_misaligned && (w_addr >= RES_LO) && (w_addr < RES_END);
        o_is_start   = (w_addr == 32'(START_ADDR));
        o_is_stat    = (w_addr == 32'(STAT_ADDR));
        o_unmapped   = !o_misaligned && !(o_is_op || o_is_res || o_is_start || o_is_stat);
        o_op_idx     = OP_IW'(w_addr >> 2);
        o_res_idx    = RES_IW'((w_addr - RES_LO) >> 2);
        o_op_we      = '0;
        if (i_write && o_is_op) begin
            o_op_we[o_op_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mm_reg_bank.sv
// Register bank and run-control FSM for the 4x4 matrix multiplier.
// Define MMRB_BYTE_STROBE_EN to add the ByteEn port and per-byte operand/status writes.
module mm_reg_bank
    import mmrb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int NUM_OPS = 64,
    parameter int NUM_RES = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [ADDR_W-1:0]         Address,
    input  logic                      Write,
    input  logic                      Read,
    input  logic [DATA_W-1:0]         WriteData,
`ifdef MMRB_BYTE_STROBE_EN
    input  logic [DATA_W/8-1:0]       ByteEn,
`endif
    output logic [DATA_W-1:0]         ReadData,
    output logic                      ReadValid,
    output logic [NUM_OPS*DATA_W-1:0] OperandBus,
    output logic                      Start,
    output logic                      Busy,
    input  logic                      Done,
    input  logic [NUM_RES*DATA_W-1:0] ResultBus,
    output logic                      Error
);

    localparam int OP_IW  = $clog2(NUM_OPS);
    localparam int RES_IW = $clog2(NUM_RES);

    state_t            r_state;
    logic              r_start;
    logic              r_busy;
    logic              r_done_flag;
    logic              r_err;
    logic              r_read_valid;
    logic [DATA_W-1:0] r_read_data;
    logic [DATA_W-1:0] r_ops [NUM_OPS];
    logic [DATA_W-1:0] r_res [NUM_RES];

    logic               w_wr;
    logic [DATA_W-1:0]  w_wmask;
    logic [NUM_OPS-1:0] w_op_we;
    logic [OP_IW-1:0]   w_op_idx;
    logic [RES_IW-1:0]  w_res_idx;
    logic               w_is_op, w_is_res, w_is_start, w_is_stat;
    logic               w_misaligned, w_unmapped;
    logic               w_idle, w_start_req, w_err_set, w_err_clr;
    logic [DATA_W-1:0]  w_rdata;

`ifdef MMRB_BYTE_STROBE_EN
    assign w_wr = Write && (|ByteEn);
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            w_wmask[b*8 +: 8] = {8{ByteEn[b]}};
        end
    end
`else
    assign w_wr    = Write;
    assign w_wmask = '1;
`endif

    mmrb_addr_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_OPS (NUM_OPS),
        .NUM_RES (NUM_RES)
    ) u_decode (
        .i_addr       (Address),
        .i_write      (w_wr),
        .o_op_we      (w_op_we),
        .o_op_idx     (w_op_idx),
        .o_res_idx    (w_res_idx),
        .o_is_op      (w_is_op),
        .o_is_res     (w_is_res),
        .o_is_start   (w_is_start),
        .o_is_stat    (w_is_stat),
        .o_misaligned (w_misaligned),
        .o_unmapped   (w_unmapped)
    );

    // Operands are locked outside IDLE; start/operand writes there are errors.
    assign w_idle      = (r_state == IDLE);
    assign w_start_req = w_wr && w_is_start && WriteData[0];
    assign w_err_set   = ((w_wr || Read) && (w_misaligned || w_unmapped))
                       || (w_wr && w_is_res)
                       || (w_wr && w_is_op && !w_idle)
                       || (w_start_req && !w_idle);
    assign w_err_clr   = w_wr && w_is_stat && WriteData[STAT_ERR] && w_wmask[STAT_ERR];

    always_comb begin
        w_rdata = '0;
        if (w_is_op) begin
            w_rdata = r_ops[w_op_idx];
        end else if (w_is_res) begin
            w_rdata = r_res[w_res_idx];
        end else if (w_is_stat) begin
            w_rdata[STAT_BUSY] = r_busy;
            w_rdata[STAT_DONE] = r_done_flag;
            w_rdata[STAT_ERR]  = r_err;
        end
    end

    // NOTE: non-blocking assignments throughout; a later one in the same block wins,
    // which is how the FSM's DoneFlag set overrides the status-read clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done_flag <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_err   <= (r_err && !w_err_clr) || w_err_set;
            if (Read && w_is_stat) begin
                r_done_flag <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start_req) begin
                        r_state     <= RUN;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done_flag <= 1'b0;
                    end
                end
                RUN: begin
                    if (Done) begin
                        r_state     <= CAPTURE;
                        r_busy      <= 1'b0;
                        r_done_flag <= 1'b1;
                    end
                end
                CAPTURE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: operand and result arrays are flops, not RAM, so they take the async reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_OPS; i++) r_ops[i] <= '0;
            for (int i = 0; i < NUM_RES; i++) r_res[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (w_op_we[i] && w_idle) begin
                    r_ops[i] <= (r_ops[i] & ~w_wmask) | (WriteData & w_wmask);
                end
            end
            if (r_state == RUN && Done) begin
                for (int i = 0; i < NUM_RES; i++) r_res[i] <= ResultBus[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_read_valid <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_read_valid <= Read;
            if (Read) begin
                r_read_data <= w_rdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_opbus
        assign OperandBus[g*DATA_W +: DATA_W] = r_ops[g];
    end

    assign ReadData  = r_read_data;
    assign ReadValid = r_read_valid;
    assign Start     = r_start;
    assign Busy      = r_busy;
    assign Error     = r_err;

endmodule

// File: tb/tb_mm_reg_bank.sv
// Self-checking bench for mm_reg_bank: directed scenarios plus random bus traffic
// compared against a transaction-level model of the register map and run control.
module tb_mm_reg_bank;

    logic         Clk;
    logic         Reset_n;
    logic [8:0]   Address;
    logic         Write;
    logic         Read;
    logic [31:0]  WriteData;
    logic [3:0]   ByteEn;
    logic [31:0]  ReadData;
    logic         ReadValid;
    logic [2047:0] OperandBus;
    logic         Start;
    logic         Busy;
    logic         Done;
    logic [511:0] ResultBus;
    logic         Error;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [31:0] m_ops [64];
    logic [31:0] m_res [16];
    bit          m_err, m_done, m_run, m_started;

    mm_reg_bank dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Address    (Address),
        .Write      (Write),
        .Read       (Read),
        .WriteData  (WriteData),
`ifdef MMRB_BYTE_STROBE_EN
        .ByteEn     (ByteEn),
`endif
        .ReadData   (ReadData),
        .ReadValid  (ReadValid),
        .OperandBus (OperandBus),
        .Start      (Start),
        .Busy       (Busy),
        .Done       (Done),
        .ResultBus  (ResultBus),
        .Error      (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ops[i] = '0;
        for (int i = 0; i < 16; i++) m_res[i] = '0;
        m_err = 0; m_done = 0; m_run = 0; m_started = 0;
    endtask

    // 0 = misaligned/unmapped, 1 = operand, 2 = result, 3 = start, 4 = status
    function automatic int kind(input logic [8:0] a);
        if (a[1:0] != 2'b00) return 0;
        if (a < 9'h100) return 1;
        if (a < 9'h140) return 2;
        if (a == 9'h180) return 3;
        if (a == 9'h184) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [8:0] a);
        case (kind(a))
            1:       return m_ops[a / 4];
            2:       return m_res[(a - 9'h100) / 4];
            4:       return {29'd0, m_err, m_done, m_run};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_apply(input logic [8:0] a, input bit rd, input bit wr,
                               input logic [31:0] d, input logic [3:0] be);
        int          k;
        bit          eff_wr, err_set;
        logic [31:0] mask;
        k       = kind(a);
        eff_wr  = wr && (be != 4'd0);
        mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        err_set = ((eff_wr || rd) && k == 0) || (eff_wr && k == 2)
                || (eff_wr && k == 1 && m_run) || (eff_wr && k == 3 && d[0] && m_run);
        m_started = 0;
        if (rd && k == 4) m_done = 0;
        if (eff_wr && k == 1 && !m_run) m_ops[a / 4] = (m_ops[a / 4] & ~mask) | (d & mask);
        if (eff_wr && k == 3 && d[0] && !m_run) begin
            m_run = 1; m_started = 1; m_done = 0;
        end
        if (eff_wr && k == 4 && d[2] && be[0]) m_err = 0;
        if (err_set) m_err = 1;
    endtask

    // One bus cycle: drive, clock, update the model, compare visible state.
    task automatic access(input logic [8:0] a, input bit rd, input bit wr,
                          input logic [31:0] d, input logic [3:0] be, input string tag);
        logic [31:0] exp_rd;
        exp_rd    = model_rd(a);
        Address   = a;
        Read      = rd;
        Write     = wr;
        WriteData = d;
        ByteEn    = be;
        tick();
        Read  = 1'b0;
        Write = 1'b0;
        model_apply(a, rd, wr, d, be);
        if (rd) begin
            check({tag, "/rdata"}, ReadData, exp_rd);
            check({tag, "/rvalid"}, ReadValid, 32'd1);
        end
        check({tag, "/err"}, Error, m_err);
        check({tag, "/busy"}, Busy, m_run);
        check({tag, "/start"}, Start, m_started);
    endtask

    task automatic pulse_done(input logic [511:0] res, input string tag);
        ResultBus = res;
        Done      = 1'b1;
        tick();
        Done = 1'b0;
        if (m_run) begin
            for (int i = 0; i < 16; i++) m_res[i] = res[i*32 +: 32];
            m_run  = 0;
            m_done = 1;
        end
        check({tag, "/busy"}, Busy, 32'd0);
        check({tag, "/start"}, Start, 32'd0);
        tick();
    endtask

    task automatic check_ops(input string tag);
        for (int i = 0; i < 64; i++) check(tag, OperandBus[i*32 +: 32], m_ops[i]);
    endtask

    function automatic logic [8:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 9'($urandom_range(0, 63) * 4);
            2:       return 9'h100 + 9'($urandom_range(0, 15) * 4);
            3:       return ($urandom_range(0, 1) != 0) ? 9'h180 : 9'h184;
            4:       return 9'h140 + 9'($urandom_range(0, 47) * 4);
            default: return 9'($urandom_range(0, 511) | 1);
        endcase
    endfunction

    initial begin
        logic [8:0]   a;
        logic [31:0]  d;
        logic [3:0]   be;
        logic [511:0] res;
        int           sel;

        Reset_n = 1'b0; Address = '0; Write = 1'b0; Read = 1'b0;
        WriteData = '0; ByteEn = 4'hF; Done = 1'b0; ResultBus = '0;
        model_reset();
        tick();
        check("rst/start", Start, 32'd0);
        check("rst/busy", Busy, 32'd0);
        check("rst/err", Error, 32'd0);
        check("rst/rvalid", ReadValid, 32'd0);
        check("rst/rdata", ReadData, 32'd0);
        check_ops("rst/ops");
        tick();
        Reset_n = 1'b1;
        tick();

        // Operand write and registered read-back
        access(9'h004, 0, 1, 32'hDEADBEEF, 4'hF, "wr004");
        check("wr004/bus", OperandBus[63:32], 32'hDEADBEEF);
        access(9'h004, 1, 0, 32'h0, 4'hF, "rd004");
        check("rd004/const", ReadData, 32'hDEADBEEF);
        tick();
        check("rd004/pulse", ReadValid, 32'd0);

        // Start with bit0 clear does nothing
        access(9'h180, 0, 1, 32'h2, 4'hF, "start0");
        check("start0/busy", Busy, 32'd0);

        // Start run: one-cycle Start pulse, Busy held
        access(9'h180, 0, 1, 32'h1, 4'hF, "start1");
        check("start1/pulse", Start, 32'd1);
        tick();
        check("run/start_low", Start, 32'd0);
        check("run/busy", Busy, 32'd1);

        // Locked operands, repeat start, W1C error clear during RUN
        access(9'h008, 0, 1, 32'h55, 4'hF, "runwr008");
        check("runwr008/reg", OperandBus[95:64], 32'h0);
        check("runwr008/err", Error, 32'd1);
        access(9'h184, 1, 0, 32'h0, 4'hF, "runstat");
        check("runstat/const", ReadData, 32'h5);
        access(9'h184, 0, 1, 32'h4, 4'hF, "w1c");
        check("w1c/err", Error, 32'd0);
        access(9'h180, 0, 1, 32'h1, 4'hF, "runstart");
        check("runstart/err", Error, 32'd1);
        access(9'h184, 0, 1, 32'h4, 4'hF, "w1c2");

        // Completion with result word0 = 0x1234
        res = '0;
        res[31:0] = 32'h1234;
        pulse_done(res, "done1");
        access(9'h100, 1, 0, 32'h0, 4'hF, "rd100");
        check("rd100/const", ReadData, 32'h1234);
        access(9'h184, 1, 0, 32'h0, 4'hF, "stat1");
        check("stat1/const", ReadData, 32'h2);
        access(9'h184, 1, 0, 32'h0, 4'hF, "stat2");
        check("stat2/const", ReadData, 32'h0);

        // Misaligned / unmapped / result-window accesses
        access(9'h002, 0, 1, 32'hFFFF_FFFF, 4'hF, "wr002");
        check("wr002/err", Error, 32'd1);
        access(9'h184, 0, 1, 32'h4, 4'hF, "w1c3");
        access(9'h1C0, 0, 1, 32'h1234_5678, 4'hF, "wr1C0");
        check("wr1C0/err", Error, 32'd1);
        access(9'h1C0, 1, 0, 32'h0, 4'hF, "rd1C0");
        check("rd1C0/const", ReadData, 32'h0);
        access(9'h104, 0, 1, 32'hABCD, 4'hF, "wr104");
        access(9'h104, 1, 0, 32'h0, 4'hF, "rd104");
        access(9'h180, 1, 0, 32'h0, 4'hF, "rd180");
        access(9'h184, 0, 1, 32'h4, 4'hF, "w1c4");

        // Read and write same cycle returns the old value
        access(9'h010, 0, 1, 32'h1111_2222, 4'hF, "rw_pre");
        access(9'h010, 1, 1, 32'h3333_4444, 4'hF, "rw");
        check("rw/old", ReadData, 32'h1111_2222);
        check("rw/new", OperandBus[159:128], 32'h3333_4444);

        // Done while idle is ignored
        res = {16{32'hFEED_F00D}};
        pulse_done(res, "idledone");
        access(9'h100, 1, 0, 32'h0, 4'hF, "idledone_rd");
        check_ops("directed/ops");

`ifdef MMRB_BYTE_STROBE_EN
        access(9'h000, 0, 1, 32'h0, 4'hF, "be_clr");
        access(9'h000, 0, 1, 32'hAABB_CCDD, 4'b0101, "be0101");
        check("be0101/reg", OperandBus[31:0], 32'h00BB_00DD);
        access(9'h1C0, 0, 1, 32'h1, 4'b0000, "be0000");
        check("be0000/err", Error, 32'd0);
`endif

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            a   = rand_addr();
            d   = $urandom;
`ifdef MMRB_BYTE_STROBE_EN
            be  = 4'($urandom);
`else
            be  = 4'hF;
`endif
            for (int i = 0; i < 16; i++) res[i*32 +: 32] = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: access(9'($urandom_range(0, 63) * 4), 0, 1, d, be, "rnd_opwr");
                3, 4:    access(a, 1, 0, d, be, "rnd_rd");
                5:       access(a, 1, 1, d, be, "rnd_rw");
                6:       access(9'h184, 0, 1, d, be, "rnd_stat");
                7:       access(a, 0, 1, d, be, "rnd_wr");
                8: begin
                    if (!m_run) access(9'h180, 0, 1, 32'h1, 4'hF, "rnd_start");
                    else pulse_done(res, "rnd_done");
                end
                default: pulse_done(res, "rnd_done2");
            endcase
            if (it % 50 == 49) check_ops("rnd/ops");
        end

        // Reset in the middle of a run
        if (!m_run) access(9'h180, 0, 1, 32'h1, 4'hF, "pre_rst_start");
        check("pre_rst/busy", Busy, 32'd1);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst/busy", Busy, 32'd0);
        check("midrst/start", Start, 32'd0);
        check_ops("midrst/ops");
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postrst/start", Start, 32'd0);
        end
        res = {16{32'hA5A5_5A5A}};
        pulse_done(res, "postrst_done");
        access(9'h100, 1, 0, 32'h0, 4'hF, "postrst_rd");
        check("postrst_rd/const", ReadData, 32'h0);
        access(9'h184, 1, 0, 32'h0, 4'hF, "postrst_stat");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
